// File: rtl/btn_cond_pkg.sv
// Package: btn_cond_pkg
// Shared definitions for the push-button conditioner.
//  - 3-bit state encoding of the debounce / auto-repeat FSM
//  - default timing constants for a 100 MHz clock
// No ports; imported by button_conditioner.
package btn_cond_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] IDLE         = 3'd0;
    localparam logic [STATE_W-1:0] PRESS_WAIT   = 3'd1;
    localparam logic [STATE_W-1:0] HELD_DELAY   = 3'd2;
    localparam logic [STATE_W-1:0] HELD_REPEAT  = 3'd3;
    localparam logic [STATE_W-1:0] RELEASE_WAIT = 3'd4;

    // Defaults for 100 MHz: 10 ms debounce, 500 ms first repeat, 100 ms repeat rate.
    localparam int DEF_STABLE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY  = 50_000_000;
    localparam int DEF_REPEAT_PERIOD = 10_000_000;
    localparam int DEF_CNT_W         = 26;

endpackage

// File: rtl/sync_2ff.sv
// Module: sync_2ff
// Two-flop synchroniser for asynchronous inputs; every bit gets its own
// independent flop pair, both flops clear to 0 in reset.
// Ports:
//  clock_at_100mhz  in   1      sampling clock
//  rst_n            in   1      synchronous, active-low reset
//  raw              in   WIDTH  asynchronous inputs
//  synced           out  WIDTH  second-flop outputs, safe to use in clock_at_100mhz domain
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clock_at_100mhz,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] synced
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic meta_reg;
        logic sync_reg;

        always_ff @(posedge clock_at_100mhz) begin
            if (!rst_n) begin
                meta_reg <= 1'b0;
                sync_reg <= 1'b0;
            end else begin
                meta_reg <= raw[gi];
                sync_reg <= meta_reg;
            end
        end

        assign synced[gi] = sync_reg;
    end

endmodule

// File: rtl/button_conditioner.sv
// Module: button_conditioner
// Conditions one raw push-button: 2-FF synchronisation, counter-based debounce
// FSM, clean level/edge outputs and auto-repeat pulses while the button is held.
// Ports:
//  clock_at_100mhz  in   1  system clock (only clock)
//  rst_n            in   1  synchronous, active-low reset
//  btn_in           in   1  raw asynchronous button, active-high
//  btn_level        out  1  debounced level
//  btn_press        out  1  1-cycle pulse on accepted press
//  btn_release      out  1  1-cycle pulse on accepted release
//  btn_repeat       out  1  1-cycle pulse on press, then per auto-repeat while held
module button_conditioner
    import btn_cond_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic clock_at_100mhz,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    // Terminal counts: the counter is cleared on every transition and only
    // compared for equality, so it never needs to wrap.
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic               btn_sync;
    logic [STATE_W-1:0] state_reg;
    logic [STATE_W-1:0] state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [CNT_W-1:0]   cnt_next;
    logic               level_reg;
    logic               level_next;
    logic               press_reg;
    logic               press_next;
    logic               release_reg;
    logic               release_next;
    logic               repeat_reg;
    logic               repeat_next;

    logic               stable_done;
    logic               delay_done;
    logic               period_done;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync (
        .clock_at_100mhz (clock_at_100mhz),
        .rst_n           (rst_n),
        .raw             (btn_in),
        .synced          (btn_sync)
    );

    assign stable_done = (cnt_reg == STABLE_LAST);
    assign delay_done  = (cnt_reg == DELAY_LAST);
    assign period_done = (cnt_reg == PERIOD_LAST);

    // State, counter and registered outputs.
    always_ff @(posedge clock_at_100mhz) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            level_reg   <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            repeat_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            level_reg   <= level_next;
            press_reg   <= press_next;
            release_reg <= release_next;
            repeat_reg  <= repeat_next;
        end
    end

    // Next state and counter. A change on the synchronised input always takes
    // priority over a terminal count reached in the same cycle.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 1'b1;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (btn_sync) begin
                    state_next = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!btn_sync) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (stable_done) begin
                    state_next = HELD_DELAY;
                    cnt_next   = '0;
                end
            end
            HELD_DELAY: begin
                if (!btn_sync) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
                end else if (delay_done) begin
                    state_next = HELD_REPEAT;
                    cnt_next   = '0;
                end
            end
            HELD_REPEAT: begin
                if (!btn_sync) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
                end else if (period_done) begin
                    cnt_next = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_sync) begin
                    // Bounce back high: repeat timing restarts, no new press.
                    state_next = HELD_DELAY;
                    cnt_next   = '0;
                end else if (stable_done) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Output decode, registered alongside the state so every output changes on
    // the same edge as the transition that causes it.
    always_comb begin
        level_next   = (state_next == HELD_DELAY)  ||
                       (state_next == HELD_REPEAT) ||
                       (state_next == RELEASE_WAIT);
        press_next   = (state_reg == PRESS_WAIT)   &&  btn_sync && stable_done;
        release_next = (state_reg == RELEASE_WAIT) && !btn_sync && stable_done;
        repeat_next  = press_next ||
                       ((state_reg == HELD_DELAY)  && btn_sync && delay_done) ||
                       ((state_reg == HELD_REPEAT) && btn_sync && period_done);
    end

    assign btn_level   = level_reg;
    assign btn_press   = press_reg;
    assign btn_release = release_reg;
    assign btn_repeat  = repeat_reg;

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner with short timing
// (STABLE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8).
// Inputs change on the falling edge; outputs are sampled 1 time unit after the
// rising edge. Output bundle order in the vector table: {level, press, release, repeat}.
module tb_button_conditioner;

    logic clock_at_100mhz;
    logic rst_n;
    logic btn_in;
    logic btn_level;
    logic btn_press;
    logic btn_release;
    logic btn_repeat;

    int n_checks = 0;
    int n_pass   = 0;

    button_conditioner #(
        .STABLE_CYCLES (4),
        .REPEAT_DELAY  (20),
        .REPEAT_PERIOD (8),
        .CNT_W         (26)
    ) dut (
        .clock_at_100mhz (clock_at_100mhz),
        .rst_n           (rst_n),
        .btn_in          (btn_in),
        .btn_level       (btn_level),
        .btn_press       (btn_press),
        .btn_release     (btn_release),
        .btn_repeat      (btn_repeat)
    );

    initial begin
        clock_at_100mhz = 1'b0;
        forever #5 clock_at_100mhz = ~clock_at_100mhz;
    end

    typedef struct {
        logic       rst_n;
        logic       btn;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Per-step logs for the hand-written sequences; index = step number.
    bit level_log   [0:127];
    bit press_log   [0:127];
    bit release_log [0:127];
    bit repeat_log  [0:127];
    int j_idx;
    int exp_q[$];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic add(input logic r, input logic b, input logic [3:0] e);
        vec_t v;
        v.rst_n = r;
        v.btn   = b;
        v.exp   = e;
        vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic b);
        @(negedge clock_at_100mhz);
        rst_n  = r;
        btn_in = b;
        @(posedge clock_at_100mhz);
        #1;
        level_log[j_idx]   = btn_level;
        press_log[j_idx]   = btn_press;
        release_log[j_idx] = btn_release;
        repeat_log[j_idx]  = btn_repeat;
        j_idx++;
    endtask

    task automatic start_seq();
        j_idx = 0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 128; i++) begin
            level_log[i]   = 1'b0;
            press_log[i]   = 1'b0;
            release_log[i] = 1'b0;
            repeat_log[i]  = 1'b0;
        end
        j_idx = 0;
    endtask

    // Compares the step indices of one pulse kind (0 press, 1 repeat, 2 release)
    // against exp_q.
    task automatic compare_pulses(input string tag, input int kind);
        int got[$];
        bit hit;
        got.delete();
        for (int i = 0; i < j_idx; i++) begin
            hit = (kind == 0) ? press_log[i] : (kind == 1) ? repeat_log[i] : release_log[i];
            if (hit) got.push_back(i);
        end
        check($sformatf("%s count", tag), got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s #%0d step", tag, i),
                  (i < got.size()) ? got[i] : -1, exp_q[i]);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        btn_in = 1'b0;
        j_idx  = 0;

        // ---------------- Table-driven part ----------------
        // Reset held for 3 cycles with the button pressed: outputs stay 0.
        for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 4'b0000);
        // After reset the button is already high: press 6 cycles after release of reset.
        for (int i = 0; i < 6; i++) add(1'b1, 1'b1, 4'b0000);
        add(1'b1, 1'b1, 4'b1101);
        add(1'b1, 1'b1, 4'b1000);
        // Reset while held: outputs clear, no release pulse.
        for (int i = 0; i < 2; i++) add(1'b0, 1'b0, 4'b0000);
        // 3-cycle bounce: rejected, nothing happens.
        for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 4'b0000);
        for (int i = 0; i < 7; i++) add(1'b1, 1'b0, 4'b0000);
        // Clean 0->1: press+repeat exactly 6 cycles after the edge, level with it.
        for (int i = 0; i < 6; i++) add(1'b1, 1'b1, 4'b0000);
        add(1'b1, 1'b1, 4'b1101);
        for (int i = 0; i < 2; i++) add(1'b1, 1'b1, 4'b1000);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock_at_100mhz);
            rst_n  = vecs[i].rst_n;
            btn_in = vecs[i].btn;
            @(posedge clock_at_100mhz);
            #1;
            check($sformatf("vec%0d outputs", i),
                  int'({btn_level, btn_press, btn_release, btn_repeat}), int'(vecs[i].exp));
        end

        // ---------------- Long hold ----------------
        // Button high for steps 0..55. It drops so that the FSM sees the low
        // level in the very cycle the repeat counter reaches terminal (press+52):
        // the release must win and no repeat is emitted there.
        start_seq();
        for (int i = 0; i < 56; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0);
        exp_q = '{6};
        compare_pulses("hold press", 0);
        exp_q = '{6, 26, 34, 42, 50};
        compare_pulses("hold repeat", 1);
        exp_q = '{62};
        compare_pulses("hold release", 2);
        check("hold level before release", int'(level_log[61]), 1);
        check("hold level after release", int'(level_log[62]), 0);

        // ---------------- Release with bounce ----------------
        // Low for 2 steps (10,11), back high from 12, then low from 38.
        start_seq();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 26; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
        exp_q = '{6};
        compare_pulses("bounce press", 0);
        exp_q = '{6, 34};
        compare_pulses("bounce repeat", 1);
        exp_q = '{44};
        compare_pulses("bounce release", 2);
        begin
            int ones;
            ones = 0;
            for (int i = 6; i < 44; i++) ones += int'(level_log[i]);
            check("bounce level held steps", ones, 38);
        end
        check("bounce level after release", int'(level_log[44]), 0);

        // ---------------- Reset in HELD_REPEAT ----------------
        start_seq();
        for (int i = 0; i < 30; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 14; i++) step(1'b1, 1'b1);
        check("rst level in reset",
              int'({level_log[30], press_log[30], release_log[30], repeat_log[30]}), 0);
        check("rst level before reset", int'(level_log[29]), 1);
        exp_q = '{6, 38};
        compare_pulses("rst press", 0);
        exp_q = '{6, 26, 38};
        compare_pulses("rst repeat", 1);
        exp_q.delete();
        compare_pulses("rst release", 2);
        check("rst level after fresh press", int'(level_log[38]), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
